// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges the in-order ALU result with buffered mult/div results
// onto the single register-file write port, killing stale buffered writes (WAW).
module writeback_arbiter #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  input  logic             md_valid,
  output logic             md_ready,
  input  logic [4:0]       md_rd,
  input  logic [31:0]      md_data,
  output logic             ctrl_writeEnable,
  output logic [4:0]       ctrl_writeReg,
  output logic [31:0]      data_writeReg,
  output logic [31:0]      pending_mask,
  output logic [CNT_W-1:0] collision_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W-1:0] ptr_t;

  logic [4:0]       rdMem   [DEPTH];
  logic [31:0]      dataMem [DEPTH];
  logic [DEPTH-1:0] validQ;
  logic [DEPTH-1:0] killQ;
  ptr_t             headPtr;
  ptr_t             tailPtr;

  logic             full;
  logic             empty;
  logic             aluWrite;
  logic             mdPush;
  logic             pop;
  logic             headKill;

  logic [DEPTH-1:0] validNext;
  logic [DEPTH-1:0] killNext;
  logic [4:0]       rdNext  [DEPTH];
  logic [31:0]      maskNext;

  // Entries occupy a contiguous circular run, so all-valid means full.
  assign full     = &validQ;
  assign empty    = ~|validQ;
  assign md_ready = ctrl_reset & ~full;

  // Writes to r0 are architecturally invisible: they never claim the port or a slot.
  assign aluWrite = alu_valid & (alu_rd != 5'd0);
  assign mdPush   = md_valid & md_ready & (md_rd != 5'd0);
  assign pop      = ~aluWrite & ~empty;
  assign headKill = killQ[headPtr];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    validNext = validQ;
    killNext  = killQ;
    maskNext  = '0;

    for (int i = 0; i < DEPTH; i++) begin
      if (aluWrite && validQ[i] && (rdMem[i] == alu_rd)) begin
        killNext[i] = 1'b1;
      end
    end

    if (pop) begin
      validNext[headPtr] = 1'b0;
      killNext[headPtr]  = 1'b0;
    end

    // A same-edge push is newer than the ALU write, so it enters unkilled.
    if (mdPush) begin
      validNext[tailPtr] = 1'b1;
      killNext[tailPtr]  = 1'b0;
    end

    for (int i = 0; i < DEPTH; i++) begin
      rdNext[i] = (mdPush && (tailPtr == ptr_t'(i))) ? md_rd : rdMem[i];
      if (validNext[i] && !killNext[i]) begin
        maskNext[rdNext[i]] = 1'b1;
      end
    end
    maskNext[0] = 1'b0;
  end

  // NOTE: payload storage carries no reset; validQ alone decides whether a slot means anything.
  always_ff @(posedge clock) begin
    if (mdPush) begin
      rdMem[tailPtr]   <= md_rd;
      dataMem[tailPtr] <= md_data;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!ctrl_reset) begin
      validQ           <= '0;
      killQ            <= '0;
      headPtr          <= '0;
      tailPtr          <= '0;
      collision_cnt    <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= 5'd0;
      data_writeReg    <= 32'd0;
      pending_mask     <= 32'd0;
    end else begin
      validQ       <= validNext;
      killQ        <= killNext;
      pending_mask <= maskNext;

      if (pop)    headPtr <= headPtr + ptr_t'(1);
      if (mdPush) tailPtr <= tailPtr + ptr_t'(1);

      if (aluWrite && !empty && (collision_cnt != {CNT_W{1'b1}})) begin
        collision_cnt <= collision_cnt + 1'b1;
      end

      if (aluWrite) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= alu_rd;
        data_writeReg    <= alu_data;
      end else if (pop && !headKill) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= rdMem[headPtr];
        data_writeReg    <= dataMem[headPtr];
      end else begin
        // Killed pop or idle slot: no write, address/data hold.
        ctrl_writeEnable <= 1'b0;
      end
    end
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage directly upstream of the 32x32 register file; sole driver of its write port (ctrl_writeEnable, ctrl_writeReg, data_writeReg).
- Merges two result sources:
  - In-order ALU pipeline result: fixed priority, no backpressure.
  - Multicycle mult/div result: valid/ready handshake, buffered in a DEPTH-entry FIFO until a free write slot.
- Kills stale buffered results to preserve write-after-write order; exports a pending-destination mask for hazard logic.

Parameters:
DEPTH, 2, mult/div buffer entries; power of two, >=2
CNT_W, 16, width of collision counter

Ports:
clock  input  1  system clock, all state on rising edge
ctrl_reset  input  1  synchronous reset, active-low
alu_valid  input  1  ALU result present this cycle
alu_rd  input  5  ALU destination register
alu_data  input  32  ALU result
md_valid  input  1  mult/div result offered
md_ready  output  1  buffer can accept (combinational)
md_rd  input  5  mult/div destination register
md_data  input  32  mult/div result
ctrl_writeEnable  output  1  register-file write enable (registered)
ctrl_writeReg  output  5  register-file write address (registered)
data_writeReg  output  32  register-file write data (registered)
pending_mask  output  32  bit r = live buffered result for register r (registered)
collision_cnt  output  CNT_W  saturating count of ALU-vs-buffer conflicts

Behaviour:
- Reset:
  - ctrl_reset=0 at an edge clears FIFO (empty), all kill bits, collision_cnt=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, pending_mask=0.
  - md_ready=0 while ctrl_reset=0. Reset mid-operation discards all buffered results; no write is issued for them.
- ALU write (alu_valid=1, alu_rd!=0) sampled at edge k:
  - Outputs after edge k are WE=1, writeReg=alu_rd, data=alu_data. Latency 1 cycle.
  - ALU always wins the port.
- alu_rd=0: no write; the slot is treated as free.
- md handshake:
  - md_ready = ctrl_reset & !full. Full is evaluated on current occupancy; a same-cycle pop does not raise ready.
  - Transfer on md_valid & md_ready at an edge.
  - md_rd=0: the transfer is accepted and discarded, nothing is pushed.
  - Otherwise push {rd, data, kill=0}.
- Drain: at an edge with a free slot and the FIFO non-empty (the FIFO state before this edge's push), pop the head.
  - Head kill=0: outputs after edge are WE=1 with head rd/data.
  - Head kill=1: pop with WE=0. This costs one cycle.
  - An entry pushed at edge k pops at edge k+1 at the earliest. Write visible after edge k+1, so latency is 2 cycles from handshake.
- Idle edge (no ALU write, no pop): WE=0; writeReg/data hold previous values.
- WAW kill: an ALU write to rd X at edge k sets kill=1 on every FIFO entry present before edge k with rd=X.
  - An md result pushed at the same edge with rd=X is treated as newer and is not killed.
- Simultaneous push and pop at one edge are legal; occupancy is unchanged. Pointers wrap modulo DEPTH.
- pending_mask:
  - Updated at each edge to the OR of one-hot(rd) over entries that are unkilled after that edge's push/pop/kill.
  - Bit 0 is always 0.
- collision_cnt: +1 at each edge where an ALU write occurs and the FIFO is non-empty; saturates at 2^CNT_W-1.

Test Plan:
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF at edge 1 -> after edge 1: WE=1, writeReg=5, data=0xDEADBEEF; after edge 2 with alu_valid=0: WE=0.
- MD only, idle ALU: md rd=7, data=0x12345678 handshaken at edge 1 -> pending_mask=0x80 after edge 1; WE=1, writeReg=7 after edge 2; pending_mask=0 after edge 2.
- Backpressure:
  - DEPTH=2; ALU writes rd=1 every cycle; md pushes rd=2 and rd=3.
  - Expected: md_ready=0 after two pushes; collision_cnt increments per cycle.
  - Drop alu_valid: rd=2 then rd=3 written in order on consecutive cycles; md_ready returns 1.
- WAW kill:
  - md rd=9 buffered behind ALU traffic; ALU writes rd=9 data=0xA.
  - Expected: pending_mask bit9 clears; the later pop gives WE=0; register 9 ends at 0xA.
- Same-edge push and ALU to one rd: ALU rd=4 and md rd=4 at the same edge -> ALU write first; md entry not killed; written next free cycle.
- r0 and reset:
  - md rd=0 is accepted and never written. alu_rd=0 gives WE=0.
  - ctrl_reset=0 with 2 buffered entries -> outputs and pending_mask=0, collision_cnt=0, no further writes after release.
